// File: rtl/dsr_pkg.sv
// Shared constants and helpers for the data SRAM responder: MMIO offsets,
// default window base and the byte-lane merge used by every RW register.
package dsr_pkg;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hbfaf_0000;

  localparam logic [15:0] TIMER_OFF     = 16'h0000;
  localparam logic [15:0] LED_OFF       = 16'h0004;
  localparam logic [15:0] NUM_OFF       = 16'h0008;
  localparam logic [15:0] SWITCH_OFF    = 16'h000c;
  localparam logic [15:0] UART_DATA_OFF = 16'h0010;
  localparam logic [15:0] UART_STAT_OFF = 16'h0014;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  we);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = we[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dsr_uart_tx.sv
// Byte-wide UART transmit front end: accepts a byte when idle, pulses
// tx_valid for one cycle and stays busy for UART_CYCLES cycles.
module dsr_uart_tx #(
  parameter int UART_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       accept_req,
  input  logic [7:0] byte_in,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy
);

  localparam int CW = $clog2(UART_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign busy = (cnt != '0);

  // Requests that arrive while busy are dropped; software polls STATUS.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (accept_req && !busy) begin
      cnt      <= CW'(UART_CYCLES);
      tx_valid <= 1'b1;
      tx_data  <= byte_in;
    end else begin
      tx_valid <= 1'b0;
      if (busy) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-port responder: word RAM with 1-cycle registered reads plus an MMIO
// window (timer, LED, number display, switches, UART transmit).
module data_sram_responder
  import dsr_pkg::*;
#(
  parameter int          RAM_AW      = 14,
  parameter logic [31:0] MMIO_BASE   = DEFAULT_MMIO_BASE,
  parameter int          UART_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data,
  input  logic [7:0]  switch,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data
);

  // The request port has no ready: every cycle with en high is a complete
  // load (we == 0) or store (we != 0), answered on the next cycle.
  logic [31:0]       mem [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_mmio;
  logic [15:0]       off;
  logic              mmio_wr;
  logic [31:0]       timer;
  logic [31:0]       timer_merged;
  logic [31:0]       led_merged;
  logic [31:0]       num_merged;
  logic [31:0]       mmio_rd;
  logic [31:0]       rd_next;
  logic              uart_busy;
  logic              uart_req;
  logic              unused_bits;

  assign is_mmio      = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign off          = {data_sram_addr[15:2], 2'b00};
  assign ram_idx      = data_sram_addr[RAM_AW+1:2];
  assign mmio_wr      = data_sram_en && is_mmio && (data_sram_we != 4'h0);
  assign timer_merged = byte_merge(timer, data_sram_wdata, data_sram_we);
  assign led_merged   = byte_merge({16'h0000, led}, data_sram_wdata, data_sram_we);
  assign num_merged   = byte_merge(num_data, data_sram_wdata, data_sram_we);
  assign uart_req     = data_sram_en && is_mmio && (off == UART_DATA_OFF) && data_sram_we[0];
  assign unused_bits  = ^{data_sram_addr[1:0], led_merged[31:16], MMIO_BASE[15:0]};

  always_comb begin
    mmio_rd = 32'h0;
    case (off)
      TIMER_OFF:     mmio_rd = timer;
      LED_OFF:       mmio_rd = {16'h0000, led};
      NUM_OFF:       mmio_rd = num_data;
      SWITCH_OFF:    mmio_rd = {24'h0, switch};
      UART_STAT_OFF: mmio_rd = {31'h0, uart_busy};
      default:       mmio_rd = 32'h0;
    endcase
  end

  // Read mux sees pre-edge state, giving read-before-write for RAM and TIMER.
  assign rd_next = is_mmio ? mmio_rd : mem[ram_idx];

  always_ff @(posedge clk) begin
    if (data_sram_en && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sram_rdata <= 32'h0;
      led             <= 16'h0;
      num_data        <= 32'h0;
      timer           <= 32'h0;
    end else begin
      if (data_sram_en) data_sram_rdata <= rd_next;
      if (mmio_wr && off == LED_OFF) led <= led_merged[15:0];
      if (mmio_wr && off == NUM_OFF) num_data <= num_merged;
      if (mmio_wr && off == TIMER_OFF) timer <= timer_merged;
      else                             timer <= timer + 32'd1;
    end
  end

  dsr_uart_tx #(
    .UART_CYCLES(UART_CYCLES)
  ) u_uart_tx (
    .clk       (clk),
    .reset     (reset),
    .accept_req(uart_req),
    .byte_in   (data_sram_wdata[7:0]),
    .tx_valid  (uart_tx_valid),
    .tx_data   (uart_tx_data),
    .busy      (uart_busy)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM, MMIO registers, timer and UART,
// with hand-computed expectations.
module tb_data_sram_responder;

  localparam int          UC = 16;
  localparam logic [31:0] MB = 32'hbfaf_0000;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  data_sram_responder #(
    .RAM_AW(14),
    .MMIO_BASE(MB),
    .UART_CYCLES(UC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .led            (led),
    .num_data       (num_data),
    .switch         (switch),
    .uart_tx_valid  (uart_tx_valid),
    .uart_tx_data   (uart_tx_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  // driver: present one request for one posedge, return at the next negedge
  task automatic drive(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(negedge clk);
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_wdata = 32'h0;
  endtask

  task automatic load(input logic [31:0] addr);
    drive(4'h0, addr, 32'h0);
  endtask

  initial begin
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch          = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num_data, 32'h0);
    check("rst_valid", {31'h0, uart_tx_valid}, 32'h0);
    check("rst_txdata", {24'h0, uart_tx_data}, 32'h0);

    // timer: 0 in the first cycle after reset, 10 ten cycles later
    reset = 1'b0;
    repeat (10) @(negedge clk);
    load(MB + 32'h0);
    check("timer_c10", data_sram_rdata, 32'd10);
    @(negedge clk);
    check("rdata_hold", data_sram_rdata, 32'd10);
    drive(4'hf, MB + 32'h0, 32'h5);
    repeat (2) @(negedge clk);
    load(MB + 32'h0);
    check("timer_load5", data_sram_rdata, 32'h7);
    drive(4'hf, MB + 32'h0, 32'hffff_ffff);
    load(MB + 32'h0);
    check("timer_max", data_sram_rdata, 32'hffff_ffff);
    load(MB + 32'h0);
    check("timer_wrap", data_sram_rdata, 32'h0);

    // RAM store/load and byte lanes
    drive(4'hf, 32'h1c00_0100, 32'h1122_3344);
    load(32'h1c00_0100);
    check("ram_word", data_sram_rdata, 32'h1122_3344);
    load(32'h1c01_0100);
    check("ram_alias", data_sram_rdata, 32'h1122_3344);
    drive(4'hf, 32'h1c00_0200, 32'haabb_ccdd);
    drive(4'b0100, 32'h1c00_0200, 32'h00ee_0000);
    check("ram_rbw", data_sram_rdata, 32'haabb_ccdd);
    load(32'h1c00_0200);
    check("ram_lane2", data_sram_rdata, 32'haaee_ccdd);

    // LED / NUM / SWITCH / unmapped
    drive(4'hf, MB + 32'h4, 32'h1234_abcd);
    check("led_out", {16'h0, led}, 32'h0000_abcd);
    load(MB + 32'h4);
    check("led_read", data_sram_rdata, 32'h0000_abcd);
    drive(4'b0001, MB + 32'h4, 32'h0000_00ff);
    check("led_lane0", {16'h0, led}, 32'h0000_abff);
    drive(4'hf, MB + 32'h8, 32'hcafe_f00d);
    load(MB + 32'h8);
    check("num_read", data_sram_rdata, 32'hcafe_f00d);
    check("num_out", num_data, 32'hcafe_f00d);
    switch = 8'h5a;
    load(MB + 32'hc);
    check("switch_read", data_sram_rdata, 32'h0000_005a);
    load(MB + 32'h100);
    check("unmapped_read", data_sram_rdata, 32'h0);

    // UART: accept, drop while busy, busy window, accept again
    drive(4'h1, MB + 32'h10, 32'h41);
    check("uart_pulse1", {31'h0, uart_tx_valid}, 32'h1);
    check("uart_data1", {24'h0, uart_tx_data}, 32'h41);
    drive(4'h1, MB + 32'h10, 32'h42);
    check("uart_single", {31'h0, uart_tx_valid}, 32'h0);
    check("uart_drop", {24'h0, uart_tx_data}, 32'h41);
    for (int i = 0; i < UC - 1; i++) exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    while (exp_q.size() > 0) begin
      load(MB + 32'h14);
      check("uart_status", data_sram_rdata, exp_q.pop_front());
    end
    drive(4'h1, MB + 32'h10, 32'h42);
    check("uart_pulse2", {31'h0, uart_tx_valid}, 32'h1);
    check("uart_data2", {24'h0, uart_tx_data}, 32'h42);

    // reset mid-transmit, with a load of LED in flight
    reset          = 1'b1;
    data_sram_en   = 1'b1;
    data_sram_addr = MB + 32'h4;
    @(negedge clk);
    reset        = 1'b0;
    data_sram_en = 1'b0;
    check("rst2_led", {16'h0, led}, 32'h0);
    check("rst2_num", num_data, 32'h0);
    check("rst2_rdata", data_sram_rdata, 32'h0);
    check("rst2_valid", {31'h0, uart_tx_valid}, 32'h0);
    load(MB + 32'h14);
    check("rst2_busy", data_sram_rdata, 32'h0);
    load(32'h1c00_0100);
    check("rst2_ram1", data_sram_rdata, 32'h1122_3344);
    load(32'h1c00_0200);
    check("rst2_ram2", data_sram_rdata, 32'haaee_ccdd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
